// File: rtl/vxc_vector_bank.sv
// rtl/vxc_vector_bank.sv - operand/result memory responder for the vXc row-streaming controller
//
// Purpose:
//   The host loads two operand vectors one element at a time. The bank then
//   serves them as NU-lane chunks on first_row_fixed/second_row_fixed and
//   advances one chunk on each read_again pulse. It also captures result chunks
//   written by the initiator and returns them to the host one element at a time.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   load_valid/sel/addr/data      host element load (accepted only in IDLE)
//   load_ready                    high while IDLE
//   start                         begin (or restart) serving from chunk 0
//   read_again                    advance to the next chunk
//   first_row_fixed               vector1 chunk, lane 0 in the low bits
//   second_row_fixed              vector2 chunk, same lane order
//   result_mem_we/counter3        result chunk write strobe / chunk index
//   result_data                   result chunk data
//   results_ready                 every result chunk has been captured
//   wr_err                        sticky, out-of-range result chunk index
//   rd_en/rd_addr/rd_data/rd_valid  host element readout, 1-cycle latency

module vxc_vector_bank #(
  parameter int N_EQ   = 16,
  parameter int EW     = 32,
  parameter int NU     = 8,
  parameter int CHUNKS = (N_EQ + NU - 1) / NU
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic                    load_sel,
  input  logic [$clog2(N_EQ)-1:0] load_addr,
  input  logic [EW-1:0]           load_data,
  output logic                    load_ready,
  input  logic                    start,
  input  logic                    read_again,
  output logic [EW*NU-1:0]        first_row_fixed,
  output logic [EW*NU-1:0]        second_row_fixed,
  input  logic                    result_mem_we,
  input  logic [31:0]             counter3,
  input  logic [EW*NU-1:0]        result_data,
  output logic                    results_ready,
  output logic                    wr_err,
  input  logic                    rd_en,
  input  logic [$clog2(N_EQ)-1:0] rd_addr,
  output logic [EW-1:0]           rd_data,
  output logic                    rd_valid
);

  localparam int AW = $clog2(N_EQ);
  localparam int PW = $clog2(CHUNKS + 1);
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [EW-1:0]    r_vec1 [N_EQ];
  logic [EW-1:0]    r_vec2 [N_EQ];
  logic [EW*NU-1:0] r_res  [CHUNKS];

  logic [PW-1:0]     r_ptr;
  logic [CHUNKS-1:0] r_bitmap;
  logic              r_results_ready;
  logic              r_wr_err;
  logic [EW*NU-1:0]  r_row1;
  logic [EW*NU-1:0]  r_row2;
  logic [EW-1:0]     r_rd_data;
  logic              r_rd_valid;

  logic              w_load_we;
  logic              w_res_we;
  logic              w_res_oob;
  logic [PW-1:0]     w_ptr_next;
  logic              w_row_update;
  logic [CHUNKS-1:0] w_bitmap_next;
  logic              w_results_ready_next;
  logic              w_wr_err_next;
  logic [EW*NU-1:0]  w_row1_next;
  logic [EW*NU-1:0]  w_row2_next;
  logic [EW-1:0]     w_rd_word;
  int                w_idx;
  int                w_rd_chunk;
  int                w_rd_lane;

  // Storage writes are gated by reset so a write arriving in the reset cycle is dropped.
  assign w_load_we = load_valid && (r_state == ST_IDLE) && (int'(load_addr) < N_EQ) && !reset;
  assign w_res_oob = result_mem_we && (counter3 >= 32'(CHUNKS));
  assign w_res_we  = result_mem_we && !w_res_oob && !reset;

  // FSM next state and load_ready
  always_comb begin
    w_state_next = r_state;
    load_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (start) w_state_next = ST_SERVE;
      end
      ST_SERVE: begin
        if (start)              w_state_next = ST_SERVE;
        else if (&w_bitmap_next) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Chunk pointer: start rewinds it, read_again advances it and saturates at CHUNKS.
  always_comb begin
    w_ptr_next   = r_ptr;
    w_row_update = 1'b0;
    if (start) begin
      w_ptr_next   = '0;
      w_row_update = 1'b1;
    end else if ((r_state == ST_SERVE) && read_again) begin
      w_row_update = 1'b1;
      if (r_ptr != PW'(CHUNKS)) w_ptr_next = r_ptr + 1'b1;
    end
  end

  // Build the chunk for the next pointer. A load in the same cycle as start is
  // forwarded so that chunk 0 already shows it. Lanes past N_EQ stay zero, and
  // so does the whole chunk once the pointer reaches CHUNKS.
  always_comb begin
    w_row1_next = '0;
    w_row2_next = '0;
    w_idx       = 0;
    for (int l = 0; l < NU; l++) begin
      w_idx = int'(w_ptr_next) * NU + l;
      if (w_idx < N_EQ) begin
        w_row1_next[l*EW +: EW] = r_vec1[w_idx[AW-1:0]];
        w_row2_next[l*EW +: EW] = r_vec2[w_idx[AW-1:0]];
        if (w_load_we && (load_addr == w_idx[AW-1:0])) begin
          if (load_sel) w_row2_next[l*EW +: EW] = load_data;
          else          w_row1_next[l*EW +: EW] = load_data;
        end
      end
    end
  end

  // Result bookkeeping: start clears the bitmap first, then a write in the same cycle still counts.
  always_comb begin
    w_bitmap_next = start ? '0 : r_bitmap;
    if (w_res_we) w_bitmap_next[counter3[CW-1:0]] = 1'b1;
    w_results_ready_next = (&w_bitmap_next) | (r_results_ready & ~start);
    w_wr_err_next        = (r_wr_err & ~start) | w_res_oob;
  end

  // Readout word select; an out-of-range address reads as zero.
  always_comb begin
    w_rd_chunk = int'(rd_addr) / NU;
    w_rd_lane  = int'(rd_addr) % NU;
    w_rd_word  = '0;
    if (int'(rd_addr) < N_EQ) w_rd_word = r_res[w_rd_chunk[CW-1:0]][w_rd_lane*EW +: EW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr           <= '0;
      r_bitmap        <= '0;
      r_results_ready <= 1'b0;
      r_wr_err        <= 1'b0;
      r_row1          <= '0;
      r_row2          <= '0;
      r_rd_data       <= '0;
      r_rd_valid      <= 1'b0;
    end else begin
      r_ptr           <= w_ptr_next;
      r_bitmap        <= w_bitmap_next;
      r_results_ready <= w_results_ready_next;
      r_wr_err        <= w_wr_err_next;
      if (w_row_update) begin
        r_row1 <= w_row1_next;
        r_row2 <= w_row2_next;
      end
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;
    end
  end

  // Storage is not cleared by reset. A read of a chunk that is written in the
  // same cycle returns the old data.
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      if (load_sel) r_vec2[load_addr] <= load_data;
      else          r_vec1[load_addr] <= load_data;
    end
    if (w_res_we) r_res[counter3[CW-1:0]] <= result_data;
  end

  assign first_row_fixed  = r_row1;
  assign second_row_fixed = r_row2;
  assign results_ready    = r_results_ready;
  assign wr_err           = r_wr_err;
  assign rd_data          = r_rd_data;
  assign rd_valid         = r_rd_valid;

endmodule

// File: tb/tb_vxc_vector_bank.sv
// tb/tb_vxc_vector_bank.sv - directed self-checking bench for vxc_vector_bank

module tb_vxc_vector_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_sel;
  logic [3:0]   load_addr;
  logic [31:0]  load_data;
  logic         start;
  logic         read_again;
  logic         result_mem_we;
  logic [31:0]  counter3;
  logic [255:0] result_data;
  logic         rd_en;
  logic [3:0]   rd_addr;

  logic         load_ready,    p_load_ready;
  logic [255:0] row1,          p_row1;
  logic [255:0] row2,          p_row2;
  logic         results_ready, p_results_ready;
  logic         wr_err,        p_wr_err;
  logic [31:0]  rd_data,       p_rd_data;
  logic         rd_valid,      p_rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vxc_vector_bank u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
    .start(start), .read_again(read_again),
    .first_row_fixed(row1), .second_row_fixed(row2),
    .result_mem_we(result_mem_we), .counter3(counter3), .result_data(result_data),
    .results_ready(results_ready), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  vxc_vector_bank #(.N_EQ(12)) u_pad (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_ready(p_load_ready),
    .start(start), .read_again(read_again),
    .first_row_fixed(p_row1), .second_row_fixed(p_row2),
    .result_mem_we(result_mem_we), .counter3(counter3), .result_data(result_data),
    .results_ready(p_results_ready), .wr_err(p_wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(p_rd_data), .rd_valid(p_rd_valid)
  );

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] v;
    for (int l = 0; l < 8; l++) v[l*32 +: 32] = base + 32'(l);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_sel = 0; load_addr = 0; load_data = 0;
    start = 0; read_again = 0; result_mem_we = 0; counter3 = 0;
    result_data = '0; rd_en = 0; rd_addr = 0;
  endtask

  task automatic do_load(input logic sel, input logic [3:0] addr, input logic [31:0] data);
    load_valid = 1; load_sel = sel; load_addr = addr; load_data = data;
    tick();
    load_valid = 0;
  endtask

  task automatic do_write(input int idx, input logic [255:0] data);
    result_mem_we = 1; counter3 = 32'(idx); result_data = data;
    tick();
    result_mem_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    n_cmp++; if (row1 !== '0) begin n_err++; $display("FAIL reset_row1 got=%h want=0", row1); end
    n_cmp++; if (row2 !== '0) begin n_err++; $display("FAIL reset_row2 got=%h want=0", row2); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
    n_cmp++; if (results_ready !== 1'b0) begin n_err++; $display("FAIL reset_results_ready got=%b want=0", results_ready); end
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL reset_wr_err got=%b want=0", wr_err); end
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd got=%b/%h want=0/0", rd_valid, rd_data); end
  endtask

  task automatic test_basic_serve();
    for (int i = 0; i < 16; i++) do_load(1'b0, 4'(i), 32'(i + 1));
    for (int i = 0; i < 16; i++) do_load(1'b1, 4'(i), 32'h100 + 32'(i));
    start = 1; tick(); start = 0;
    n_cmp++; if (row1 !== mk(32'd1)) begin n_err++; $display("FAIL serve_c0_row1 got=%h want=%h", row1, mk(32'd1)); end
    n_cmp++; if (row2 !== mk(32'h100)) begin n_err++; $display("FAIL serve_c0_row2 got=%h want=%h", row2, mk(32'h100)); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL serve_load_ready got=%b want=0", load_ready); end
    read_again = 1; tick(); read_again = 0;
    n_cmp++; if (row1 !== mk(32'd9)) begin n_err++; $display("FAIL serve_c1_row1 got=%h want=%h", row1, mk(32'd9)); end
    n_cmp++; if (row2 !== mk(32'h108)) begin n_err++; $display("FAIL serve_c1_row2 got=%h want=%h", row2, mk(32'h108)); end
    read_again = 1; tick();
    n_cmp++; if (row1 !== '0 || row2 !== '0) begin n_err++; $display("FAIL serve_end_zero got=%h/%h want=0", row1, row2); end
    tick(); read_again = 0;
    n_cmp++; if (row1 !== '0 || row2 !== '0) begin n_err++; $display("FAIL serve_saturate got=%h/%h want=0", row1, row2); end
  endtask

  task automatic test_load_blocked();
    load_valid = 1; load_sel = 0; load_addr = 0; load_data = 32'hDEAD;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL blocked_load_ready got=%b want=0", load_ready); end
    tick(); load_valid = 0;
    start = 1; tick(); start = 0;
    n_cmp++; if (row1 !== mk(32'd1)) begin n_err++; $display("FAIL blocked_vector got=%h want=%h", row1, mk(32'd1)); end
  endtask

  task automatic test_reset_mid_serve();
    reset = 1; read_again = 1; result_mem_we = 1; counter3 = 1; result_data = mk(32'hBAD00);
    tick();
    reset = 0; read_again = 0; result_mem_we = 0;
    n_cmp++; if (row1 !== '0 || row2 !== '0) begin n_err++; $display("FAIL midrst_rows got=%h/%h want=0", row1, row2); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL midrst_load_ready got=%b want=1", load_ready); end
    start = 1; tick(); start = 0;
    n_cmp++; if (row1 !== mk(32'd1)) begin n_err++; $display("FAIL midrst_restart_row1 got=%h want=%h", row1, mk(32'd1)); end
    n_cmp++; if (row2 !== mk(32'h100)) begin n_err++; $display("FAIL midrst_restart_row2 got=%h want=%h", row2, mk(32'h100)); end
  endtask

  task automatic test_result_capture();
    do_write(1, mk(32'h200));
    n_cmp++; if (results_ready !== 1'b0) begin n_err++; $display("FAIL cap_partial got=%b want=0", results_ready); end
    do_write(0, mk(32'h300));
    n_cmp++; if (results_ready !== 1'b1) begin n_err++; $display("FAIL cap_ready got=%b want=1", results_ready); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL cap_idle got=%b want=1", load_ready); end
    n_cmp++; if (row1 !== mk(32'd1)) begin n_err++; $display("FAIL cap_row_hold got=%h want=%h", row1, mk(32'd1)); end
    rd_en = 1; rd_addr = 9; tick(); rd_en = 0;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h201) begin n_err++; $display("FAIL rd_addr9 got=%b/%h want=1/00000201", rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_drop got=%b want=0", rd_valid); end
  endtask

  task automatic test_dup_and_oob();
    start = 1; tick(); start = 0;
    n_cmp++; if (results_ready !== 1'b0) begin n_err++; $display("FAIL start_clears_ready got=%b want=0", results_ready); end
    do_write(0, mk(32'h400));
    do_write(0, mk(32'h500));
    n_cmp++; if (results_ready !== 1'b0) begin n_err++; $display("FAIL dup_no_ready got=%b want=0", results_ready); end
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL dup_wr_err got=%b want=0", wr_err); end
    do_write(5, {8{32'hEEEEEEEE}});
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL oob_wr_err got=%b want=1", wr_err); end
    n_cmp++; if (results_ready !== 1'b0) begin n_err++; $display("FAIL oob_ready got=%b want=0", results_ready); end
    rd_en = 1; rd_addr = 13; tick();
    n_cmp++; if (rd_data !== 32'h205) begin n_err++; $display("FAIL oob_storage got=%h want=00000205", rd_data); end
    n_cmp++; if (p_rd_valid !== 1'b1 || p_rd_data !== 32'd0) begin n_err++; $display("FAIL rd_beyond_neq got=%b/%h want=1/0", p_rd_valid, p_rd_data); end
    rd_addr = 0; result_mem_we = 1; counter3 = 0; result_data = mk(32'h600);
    tick(); result_mem_we = 0;
    n_cmp++; if (rd_data !== 32'h500) begin n_err++; $display("FAIL rd_wr_collision got=%h want=00000500", rd_data); end
    tick(); rd_en = 0;
    n_cmp++; if (rd_data !== 32'h600) begin n_err++; $display("FAIL rd_after_write got=%h want=00000600", rd_data); end
  endtask

  task automatic test_padding();
    logic [255:0] exp_pad;
    logic [255:0] exp_c0;
    reset = 1; tick(); reset = 0;
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL rst_clears_wr_err got=%b want=0", wr_err); end
    for (int i = 0; i < 16; i++) do_load(1'b1, 4'(i), 32'hFFFFFFFF);
    for (int i = 1; i < 16; i++) do_load(1'b0, 4'(i), 32'hFFFFFFFF);
    load_valid = 1; load_sel = 0; load_addr = 0; load_data = 32'h12345678; start = 1;
    tick();
    load_valid = 0; start = 0;
    exp_c0 = {8{32'hFFFFFFFF}};
    exp_c0[31:0] = 32'h12345678;
    n_cmp++; if (row1 !== exp_c0) begin n_err++; $display("FAIL load_with_start got=%h want=%h", row1, exp_c0); end
    read_again = 1; tick(); read_again = 0;
    exp_pad = '0;
    for (int l = 0; l < 4; l++) exp_pad[l*32 +: 32] = 32'hFFFFFFFF;
    n_cmp++; if (p_row1 !== exp_pad) begin n_err++; $display("FAIL pad_row1 got=%h want=%h", p_row1, exp_pad); end
    n_cmp++; if (p_row2 !== exp_pad) begin n_err++; $display("FAIL pad_row2 got=%h want=%h", p_row2, exp_pad); end
    n_cmp++; if (row1 !== {8{32'hFFFFFFFF}}) begin n_err++; $display("FAIL full_c1 got=%h want=all-ones", row1); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_basic_serve();
    test_load_blocked();
    test_reset_mid_serve();
    test_result_capture();
    test_dup_and_oob();
    test_padding();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
